// File: rtl/spike_window_collector_if.sv
// Record stream from the spike window collector to readout/learning logic.
// The collector drives the master side; the consumer drives out_ready.
interface spike_window_collector_if #(
  parameter int CNT_W = 5,
  parameter int IDX_W = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [IDX_W-1:0] out_idx;

  modport master (output out_valid, output out_count, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_count, input out_idx, output out_ready);
endinterface

// File: rtl/spike_window_collector.sv
// Counts refractory-filtered spikes over fixed windows of enabled cycles and
// queues one {window index, count} record per window in a small FIFO.
module spike_window_collector #(
  parameter int WINDOW  = 16,
  parameter int CNT_W   = 5,
  parameter int REFRACT = 1,
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 4,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     spike_in,
  input  logic                     clr_ovf,
  spike_window_collector_if.master rec,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     ovf
);
  localparam int TMR_W = $clog2(WINDOW);
  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = IDX_W + CNT_W;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRACT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [REF_W-1:0] refr_reg, refr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             ovf_reg, ovf_next;

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] head;

  logic             accept, window_end, head_valid, full, pop, push, drop;
  logic [CNT_W-1:0] count_sum;

  always_comb begin
    accept     = en & spike_in & (refr_reg == '0);
    count_sum  = (count_reg == CNT_MAX) ? CNT_MAX : count_reg + CNT_W'(accept);
    window_end = en & (timer_reg == TMR_LAST);
    head_valid = (level_reg != '0);
    full       = (level_reg == LVL_FULL);
    pop        = head_valid & rec.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push       = window_end & (~full | pop);
    drop       = window_end & full & ~pop;

    timer_next  = timer_reg;
    refr_next   = refr_reg;
    count_next  = count_reg;
    idx_next    = idx_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    ovf_next    = ovf_reg;

    if (accept) begin
      refr_next = REF_LOAD;
    end else if (en && refr_reg != '0) begin
      refr_next = refr_reg - REF_W'(1);
    end

    if (en) begin
      timer_next = window_end ? '0 : timer_reg + TMR_W'(1);
      count_next = window_end ? '0 : count_sum;
    end

    // Index advances even on a dropped record so the gap is visible downstream.
    if (window_end) begin
      idx_next = idx_reg + IDX_W'(1);
    end

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase

    if (drop) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg  <= '0;
      refr_reg   <= '0;
      count_reg  <= '0;
      idx_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      timer_reg  <= timer_next;
      refr_reg   <= refr_next;
      count_reg  <= count_next;
      idx_reg    <= idx_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= {idx_reg, count_sum};
    end
  end

  assign head          = mem[rd_ptr_reg];
  assign rec.out_valid = head_valid;
  assign rec.out_count = head_valid ? head[CNT_W-1:0] : '0;
  assign rec.out_idx   = head_valid ? head[REC_W-1:CNT_W] : '0;
  assign fifo_level    = level_reg;
  assign ovf           = ovf_reg;
endmodule
